// File: rtl/hls_target_mul_arbiter.sv
// Round-robin arbiter sharing one unsigned A_W x B_W multiplier among NUM_REQ
// requesters, feeding a 2-stage elastic pipeline with a tagged, backpressured output.
module hls_target_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 13,
  parameter int B_W     = 8,
  parameter int P_W     = 21
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_W-1:0]         out_p,
  output logic [ID_W-1:0]        out_id,
  output logic                   busy
);

  function automatic logic [P_W-1:0] mul_full(input logic [A_W-1:0] a,
                                              input logic [B_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

  logic                r_vld_p1;
  logic [A_W-1:0]      r_a_p1;
  logic [B_W-1:0]      r_b_p1;
  logic [ID_W-1:0]     r_id_p1;
  logic                r_vld_p2;
  logic [P_W-1:0]      r_prod_p2;
  logic [ID_W-1:0]     r_id_p2;
  logic [ID_W-1:0]     r_last_grant;

  logic                w_s2_en;
  logic                w_s1_en;
  logic                w_any_grant;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic [A_W-1:0]      w_a;
  logic [B_W-1:0]      w_b;
  logic [P_W-1:0]      w_prod;
  int                  w_idx;

  assign w_s2_en = !r_vld_p2 || out_ready;
  assign w_s1_en = !r_vld_p1 || w_s2_en;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_grant     = '0;
    w_any_grant = 1'b0;
    w_gidx      = '0;
    w_idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_any_grant && w_s1_en && !ap_rst &&
          ((req_valid >> w_idx) & NUM_REQ'(1)) != '0) begin
        w_any_grant = 1'b1;
        w_gidx      = ID_W'(w_idx);
        w_grant     = NUM_REQ'(1) << w_idx;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_a       = A_W'(req_a >> (int'(w_gidx) * A_W));
  assign w_b       = B_W'(req_b >> (int'(w_gidx) * B_W));
  assign w_prod    = mul_full(r_a_p1, r_b_p1);

  // Control and output registers: stage 1 -> stage 2 boundary.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_prod_p2    <= '0;
      r_id_p2      <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (w_s2_en) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_prod_p2 <= w_prod;
          r_id_p2   <= r_id_p1;
        end
      end
      if (w_s1_en) r_vld_p1 <= w_any_grant;
      if (w_any_grant) r_last_grant <= w_gidx;
    end
  end

  // Arbiter -> stage 1 boundary: operand capture needs no reset.
  always_ff @(posedge ap_clk) begin
    if (w_any_grant) begin
      r_a_p1  <= w_a;
      r_b_p1  <= w_b;
      r_id_p1 <= w_gidx;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_p     = r_prod_p2;
  assign out_id    = r_id_p2;
  assign busy      = r_vld_p1 | r_vld_p2;

endmodule

// File: tb/tb_hls_target_mul_arbiter.sv
// Bench for hls_target_mul_arbiter: directed vectors, an in-order queue model of
// the shared multiplier pipeline, and hand-computed literal expectations.
module tb_hls_target_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 13;
  localparam int B_W     = 8;
  localparam int P_W     = 21;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [P_W-1:0]         out_p;
  logic [ID_W-1:0]        out_id;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;

  hls_target_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_id(out_id), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Model: results in flight kept oldest-first; each sits either waiting
  // (stage 1) or presented at the output (stage 2).
  typedef struct {
    int unsigned p;
    int          id;
    int          stage;
  } item_t;

  item_t m_q[$];
  int    m_last = NUM_REQ - 1;

  function automatic int model_grant();
    bit has_wait, has_out, slot_free;
    has_wait = 1'b0;
    has_out  = 1'b0;
    foreach (m_q[i]) begin
      if (m_q[i].stage == 1) has_wait = 1'b1;
      if (m_q[i].stage == 2) has_out  = 1'b1;
    end
    slot_free = !has_wait || !has_out || out_ready;
    if (ap_rst || !slot_free) return -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (m_last + k) % NUM_REQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge ap_clk or posedge ap_rst) begin
    int g;
    item_t it;
    if (ap_rst) begin
      m_q.delete();
      m_last = NUM_REQ - 1;
    end else begin
      g = model_grant();
      if (m_q.size() > 0 && m_q[0].stage == 2 && out_ready) void'(m_q.pop_front());
      if (m_q.size() > 0 && m_q[0].stage == 1) m_q[0].stage = 2;
      if (g >= 0) begin
        it.p     = int'(req_a[g*A_W +: A_W]) * int'(req_b[g*B_W +: B_W]);
        it.id    = g;
        it.stage = 1;
        m_q.push_back(it);
        m_last = g;
      end
    end
  end

  always @(negedge ap_clk) begin
    int   g;
    logic exp_ov;
    g      = model_grant();
    exp_ov = (m_q.size() > 0) && (m_q[0].stage == 2);
    check("m_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("m_out_valid", 32'(out_valid), 32'(exp_ov));
    check("m_busy", 32'(busy), 32'(m_q.size() > 0));
    if (exp_ov) begin
      check("m_out_p", 32'(out_p), m_q[0].p);
      check("m_out_id", 32'(out_id), 32'(m_q[0].id));
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int idx, input int a, input int b);
    req_a[idx*A_W +: A_W] = A_W'(a);
    req_b[idx*B_W +: B_W] = B_W'(b);
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;

    @(negedge ap_clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_p", 32'(out_p), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    @(posedge ap_clk);
    #2;
    ap_rst    = 1'b0;
    req_valid = '0;

    // single request from requester 2
    set_req(2, 100, 7);
    req_valid = 4'b0100;
    @(negedge ap_clk);
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    check("single_not_yet", 32'(out_valid), 0);
    tick();
    @(negedge ap_clk);
    check("single_valid", 32'(out_valid), 1);
    check("single_p", 32'(out_p), 700);
    check("single_id", 32'(out_id), 2);

    // operand extremes
    tick();
    set_req(0, 8191, 255);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    check("max_ready", 32'(req_ready), 32'b0001);
    tick();
    set_req(1, 0, 255);
    req_valid = 4'b0010;
    @(negedge ap_clk);
    check("zero_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    check("max_p", 32'(out_p), 2088705);
    check("max_id", 32'(out_id), 0);
    tick();
    @(negedge ap_clk);
    check("zero_valid", 32'(out_valid), 1);
    check("zero_p", 32'(out_p), 0);
    check("zero_id", 32'(out_id), 1);

    // lone requester 3, then all four contend
    tick();
    set_req(3, 55, 2);
    req_valid = 4'b1000;
    @(negedge ap_clk);
    check("sparse3_ready", 32'(req_ready), 32'b1000);
    tick();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 10 + i, i + 1);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      check("rr_ready", 32'(req_ready), 32'd1 << (c % 4));
      if (c >= 2) check("rr_out_id", 32'(out_id), 32'((c - 2) % 4));
      tick();
    end
    req_valid = '0;

    // wrap 3 -> 0
    set_req(3, 7, 9);
    req_valid = 4'b1000;
    @(negedge ap_clk);
    check("wrap3_ready", 32'(req_ready), 32'b1000);
    tick();
    set_req(0, 3, 3);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    check("wrap0_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // backpressure on a stream from requester 1
    out_ready = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 11, 3);
    @(negedge ap_clk);
    check("bp_acc0", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 12, 3);
    @(negedge ap_clk);
    check("bp_acc1", 32'(req_ready), 32'b0010);
    tick();
    set_req(1, 13, 3);
    for (int c = 2; c < 5; c++) begin
      @(negedge ap_clk);
      check("bp_stall_ready", 32'(req_ready), 0);
      check("bp_hold_p", 32'(out_p), 33);
      check("bp_hold_valid", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    check("bp_resume_ready", 32'(req_ready), 32'b0010);
    check("bp_drain0", 32'(out_p), 33);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    check("bp_drain1", 32'(out_p), 36);
    tick();
    @(negedge ap_clk);
    check("bp_drain2", 32'(out_p), 39);
    tick();
    tick();
    tick();

    // reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 200 + i, 5);
    req_valid = 4'b1111;
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_valid", 32'(out_valid), 1);
    #2;
    ap_rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(req_ready), 0);
    @(posedge ap_clk);
    #2;
    ap_rst    = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    check("post_rst_no_stale", 32'(out_valid), 0);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    check("post_rst_gap", 32'(out_valid), 0);
    tick();
    @(negedge ap_clk);
    check("post_rst_id", 32'(out_id), 0);
    check("post_rst_p", 32'(out_p), 1000);
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
